// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Three-port write-back arbiter in front of a single register-file write
//   port. Each requester (0 = ALU, 1 = load unit, 2 = link) owns a one-entry
//   holding buffer. One buffered entry is retired per cycle onto the
//   registered write port unless the register file stalls.
//
// Handshake: a request on port p transfers on a rising edge where
//   req_valid[p] and req_ready[p] are both high. req_ready[p] never depends
//   on req_valid[p] itself; it may depend on lower-index ports' req_valid,
//   because two ports cannot be accepted for the same register in one cycle.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   req_valid    [2:0]   per-port request valid
//   req_addr     [11:0]  per-port destination register, port p at [4p+3:4p]
//   req_data     [95:0]  per-port write data, port p at [32p+31:32p]
//   req_ready    [2:0]   per-port accept
//   rf_hold      register-file stall; no write issued while high
//   we           registered write enable
//   waddr        [3:0]   registered write address
//   wdata        [31:0]  registered write data
//   pc_redirect  high together with we when waddr == 15
//   busy         [15:0]  busy[r] high while a buffered entry targets r
//
// Configuration
//   WB_ARB_FIXED_PRIO_EN  defined: fixed priority, port 2 > port 1 > port 0,
//                         no round-robin pointer.
//                         undefined (default): round-robin grant.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [11:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        rf_hold,
  output logic        we,
  output logic [3:0]  waddr,
  output logic [31:0] wdata,
  output logic        pc_redirect,
  output logic [15:0] busy
);

  // Holding buffers
  logic [2:0]  r_buf_valid;
  logic [3:0]  r_buf_addr [3];
  logic [31:0] r_buf_data [3];

  // Registered write port
  logic        r_we;
  logic [3:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_pc_redirect;

  logic [3:0]  w_in_addr [3];
  logic [31:0] w_in_data [3];
  logic [2:0]  w_grant;
  logic [2:0]  w_ready;
  logic [2:0]  w_accept;
  logic [3:0]  w_gnt_addr;
  logic [31:0] w_gnt_data;
  logic [15:0] w_busy;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_in_addr[p] = req_addr[4*p +: 4];
      w_in_data[p] = req_data[32*p +: 32];
    end
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  // Fixed priority: port 2 > port 1 > port 0.
  always_comb begin
    w_grant = 3'b000;
    if (!rf_hold) begin
      if (r_buf_valid[2])      w_grant = 3'b100;
      else if (r_buf_valid[1]) w_grant = 3'b010;
      else if (r_buf_valid[0]) w_grant = 3'b001;
    end
  end
`else
  // r_prio names the highest-priority port for the current cycle. After
  // granting port i it becomes i+1 (mod 3), so order is i+1, i+2, i.
  logic [1:0] r_prio;

  always_comb begin
    w_grant = 3'b000;
    if (!rf_hold) begin
      case (r_prio)
        2'd1: begin
          if (r_buf_valid[1])      w_grant = 3'b010;
          else if (r_buf_valid[2]) w_grant = 3'b100;
          else if (r_buf_valid[0]) w_grant = 3'b001;
        end
        2'd2: begin
          if (r_buf_valid[2])      w_grant = 3'b100;
          else if (r_buf_valid[0]) w_grant = 3'b001;
          else if (r_buf_valid[1]) w_grant = 3'b010;
        end
        default: begin
          if (r_buf_valid[0])      w_grant = 3'b001;
          else if (r_buf_valid[1]) w_grant = 3'b010;
          else if (r_buf_valid[2]) w_grant = 3'b100;
        end
      endcase
    end
  end

  // Pointer freezes while rf_hold is high because no grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 2'd0;
    end else begin
      case (w_grant)
        3'b001:  r_prio <= 2'd1;
        3'b010:  r_prio <= 2'd2;
        3'b100:  r_prio <= 2'd0;
        default: r_prio <= r_prio;
      endcase
    end
  end
`endif

  // Accept logic. A port may refill its own buffer in the cycle that buffer
  // is granted. A request is refused while any other buffer (granted this
  // cycle or not) holds the same register, and when a lower-index port is
  // accepting that register now; together these keep at most one buffered
  // entry per register, so same-register writes retire in acceptance order.
  always_comb begin
    logic [2:0] rdy;
    logic [2:0] acc;
    rdy = 3'b000;
    acc = 3'b000;
    for (int p = 0; p < 3; p++) begin
      rdy[p] = !reset && (!r_buf_valid[p] || w_grant[p]);
      for (int q = 0; q < 3; q++) begin
        if (q != p && r_buf_valid[q] && (r_buf_addr[q] == w_in_addr[p]))
          rdy[p] = 1'b0;
        if (q < p && acc[q] && (w_in_addr[q] == w_in_addr[p]))
          rdy[p] = 1'b0;
      end
      acc[p] = rdy[p] && req_valid[p];
    end
    w_ready  = rdy;
    w_accept = acc;
  end

  // Grant is one-hot, so an OR of the gated entries is the selected entry.
  always_comb begin
    w_gnt_addr = 4'h0;
    w_gnt_data = 32'h0;
    for (int p = 0; p < 3; p++) begin
      if (w_grant[p]) begin
        w_gnt_addr = w_gnt_addr | r_buf_addr[p];
        w_gnt_data = w_gnt_data | r_buf_data[p];
      end
    end
  end

  always_comb begin
    w_busy = 16'h0;
    for (int p = 0; p < 3; p++) begin
      if (r_buf_valid[p]) w_busy[r_buf_addr[p]] = 1'b1;
    end
  end

  // Buffers: a refill on accept takes precedence over the free on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 3'b000;
      for (int p = 0; p < 3; p++) begin
        r_buf_addr[p] <= 4'h0;
        r_buf_data[p] <= 32'h0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (w_accept[p]) begin
          r_buf_valid[p] <= 1'b1;
          r_buf_addr[p]  <= w_in_addr[p];
          r_buf_data[p]  <= w_in_data[p];
        end else if (w_grant[p]) begin
          r_buf_valid[p] <= 1'b0;
        end
      end
    end
  end

  // Write port: address and data hold their last values on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we          <= 1'b0;
      r_waddr       <= 4'h0;
      r_wdata       <= 32'h0;
      r_pc_redirect <= 1'b0;
    end else if (|w_grant) begin
      r_we          <= 1'b1;
      r_waddr       <= w_gnt_addr;
      r_wdata       <= w_gnt_data;
      r_pc_redirect <= (w_gnt_addr == 4'hF);
    end else begin
      r_we          <= 1'b0;
      r_pc_redirect <= 1'b0;
    end
  end

  // Outputs are forced to their idle values for the whole time reset is
  // high, including the first cycle before the reset edge is taken.
  assign req_ready   = w_ready;
  assign we          = r_we && !reset;
  assign waddr       = reset ? 4'h0 : r_waddr;
  assign wdata       = reset ? 32'h0 : r_wdata;
  assign pc_redirect = r_pc_redirect && !reset;
  assign busy        = reset ? 16'h0 : w_busy;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
  - clk  input  1  clock; all state updates on rising edge
  - reset  input  1  reset, synchronous, active-high
  - req_valid  input  3  per-port write request valid; port 0 ALU, port 1 load unit, port 2 link
  - req_addr  input  12  per-port destination register, 4 bits per port, port p at bits [4p+3:4p]
  - req_data  input  96  per-port write data, 32 bits per port, port p at bits [32p+31:32p]
  - req_ready  output  3  per-port accept; a transfer occurs when valid and ready are both high
  - rf_hold  input  1  register file write-port stall; no write issued while high
  - we  output  1  register-file write enable, registered
  - waddr  output  4  register-file write address, registered
  - wdata  output  32  register-file write data, registered
  - pc_redirect  output  1  registered pulse, high with we when waddr == 15
  - busy  output  16  busy[r] high while any buffered entry targets register r
REQ-002 There SHALL be no parameters; the port count is fixed at 3 and the data width at 32.

Function
REQ-003 Each port SHALL own a 1-entry holding buffer (valid, addr[3:0], data[31:0]).
REQ-004 req_ready[p] SHALL be high only when all of the following hold:
  - the port p buffer is empty or is being granted this cycle;
  - req_addr[p] matches no other occupied buffer;
  - no lower-index port is accepting the same address this cycle;
  - reset is low.
REQ-005 On accept, the buffer SHALL capture req_addr and req_data on that clock edge.
REQ-006 Each cycle with rf_hold low and at least one occupied buffer, exactly one buffer SHALL be granted.
REQ-007 The grant SHALL be round-robin: after granting port i, priority order is i+1, i+2, i (mod 3).
REQ-008 The grant SHALL register we=1, waddr and wdata from the granted buffer and free that buffer at the same edge.
REQ-009 With no grant, we SHALL be 0 the next cycle; waddr and wdata SHALL hold their last values.
REQ-010 Minimum latency SHALL be 1 cycle from the accept edge to the edge where we=1 is visible, and 2 edges from request to register-file write.
REQ-011 pc_redirect SHALL equal we AND (waddr == 15).
REQ-012 busy SHALL be combinational from the buffer contents:
  - set from the cycle after accept;
  - cleared in the cycle after grant.
REQ-013 A buffer SHALL accept a new request in the same cycle it is granted, giving back-to-back throughput of 1 write per cycle.
REQ-014 While rf_hold is high, buffers SHALL retain their contents, the round-robin pointer SHALL not advance, and we SHALL be 0 the next cycle.
REQ-015 Writes to the same register SHALL retire in acceptance order; REQ-004 guarantees at most one buffered entry per register.

Reset
REQ-016 While reset is high, the block SHALL force the following:
  - all buffers empty; req_ready = 3'b000;
  - we = 0, waddr = 4'h0, wdata = 32'h0, pc_redirect = 0, busy = 16'h0;
  - round-robin pointer set so that port 0 has highest priority.
REQ-017 Reset asserted mid-operation SHALL discard all buffered entries without issuing their writes.

Configuration
REQ-018 When macro WB_ARB_FIXED_PRIO_EN is defined, grant SHALL be fixed priority (port 2 > port 1 > port 0) and the round-robin pointer SHALL be absent.
REQ-019 When WB_ARB_FIXED_PRIO_EN is undefined, grant SHALL be round-robin per REQ-007.

Verification
REQ-020 Single write: port 0 writes addr 3 with data 32'hDEADBEEF.
  - Response: one cycle later we=1, waddr=3, wdata=32'hDEADBEEF, busy[3] cleared after the grant, pc_redirect=0.
REQ-021 Round-robin fairness: all three ports present addrs 1, 2, 4 in the same cycle.
  - Response: grants in order 0, 1, 2 on consecutive cycles.
  - With WB_ARB_FIXED_PRIO_EN, grants in order 2, 1, 0.
REQ-022 Same-address conflict: ports 0 and 1 both present addr 7 in the same cycle (data 32'h1, then 32'h2).
  - Response: port 0 accepted, req_ready[1]=0.
  - Port 1 accepted after port 0 is granted; final register writes are 32'h1 then 32'h2.
REQ-023 PC write with hold: port 2 writes addr 15 with data 32'h100 while rf_hold is high for 3 cycles.
  - Response: we=0 throughout the hold, busy[15]=1.
  - Once rf_hold falls: we=1, waddr=15, pc_redirect=1.
REQ-024 Reset mid-operation: fill all three buffers, then assert reset for 1 cycle.
  - Response: busy=16'h0, we=0, no buffered write issued.
  - After reset releases, port 0 has highest priority.
REQ-025 Back-to-back throughput: port 1 streams addrs 0..5 with valid held high.
  - Response: req_ready[1] stays high, and we is high for 6 consecutive cycles.
